// File: rtl/lzd_32bit_if.sv
// Data bundle for the registered leading-zero detector.
// The master drives the word; the slave returns the count and non-zero flag.
interface lzd_32bit_if #(
   parameter int WIDTH = 32
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] in;
   logic [CW-1:0]    out;
   logic             valid;

   modport master (output in, input out, valid);
   modport slave  (input in, output out, valid);
endinterface

// File: rtl/lzd_32bit.sv
// Registered leading-zero detector for 16- or 32-bit words.
// A pairwise merge tree of 2-bit cells feeds a single output register.
module lzd_32bit #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic        clk,
   input  logic        rst,
   lzd_32bit_if.slave  bus
);

   if (WIDTH != 16 && WIDTH != 32) begin : g_bad_width
      $error("lzd_32bit: WIDTH must be 16 or 32");
   end

   localparam int NC = WIDTH / 2;

   logic [CW-1:0] cnt [CW][NC];
   logic          vld [CW][NC];

   logic [CW-1:0] out_d, out_q;
   logic          valid_d, valid_q;

   always_comb begin
      for (int l = 0; l < CW; l++) begin
         for (int i = 0; i < NC; i++) begin
            cnt[l][i] = '0;
            vld[l][i] = 1'b0;
         end
      end
      for (int i = 0; i < NC; i++) begin
         vld[0][i] = bus.in[2*i+1] | bus.in[2*i];
         cnt[0][i] = {{(CW-1){1'b0}}, ~bus.in[2*i+1]};
      end
      // Upper half wins when valid; otherwise its full width is zeros.
      for (int l = 1; l < CW; l++) begin
         for (int i = 0; i < (WIDTH >> (l + 1)); i++) begin
            if (vld[l-1][2*i+1])
               cnt[l][i] = cnt[l-1][2*i+1];
            else
               cnt[l][i] = cnt[l-1][2*i] | (CW'(1) << l);
            vld[l][i] = vld[l-1][2*i+1] | vld[l-1][2*i];
         end
      end
      valid_d = vld[CW-1][0];
      out_d   = valid_d ? cnt[CW-1][0] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign bus.out   = out_q;
   assign bus.valid = valid_q;

endmodule

// File: tb/tb_lzd_32bit.sv
// Bench for lzd_32bit: 32- and 16-bit instances side by side,
// directed vectors then a random sweep against a leading-zero model.
module tb_lzd_32bit;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lzd_32bit_if #(.WIDTH(32)) b32 ();
   lzd_32bit_if #(.WIDTH(16)) b16 ();

   lzd_32bit #(.WIDTH(32)) dut32 (
      .clk (clk),
      .rst (rst),
      .bus (b32.slave)
   );

   lzd_32bit #(.WIDTH(16)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (b16.slave)
   );

   function automatic int lz_ref(input logic [31:0] v, input int w);
      for (int b = w - 1; b >= 0; b--)
         if (v[b]) return w - 1 - b;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input int eo, input logic ev);
      chk({tag, ".out32"}, 32'(b32.out), 32'(eo));
      chk({tag, ".val32"}, 32'(b32.valid), 32'(ev));
   endtask

   task automatic chk16(input string tag, input int eo, input logic ev);
      chk({tag, ".out16"}, 32'(b16.out), 32'(eo));
      chk({tag, ".val16"}, 32'(b16.valid), 32'(ev));
   endtask

   task automatic step(input logic [31:0] v32, input logic [15:0] v16);
      @(negedge clk);
      b32.in = v32;
      b16.in = v16;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] r32;
   logic [15:0] r16;

   initial begin
      b32.in = 32'hFFFF_FFFF;
      b16.in = 16'hFFFF;

      // Reset held with all-ones input
      #1;
      chk32("rst_async", 0, 1'b0);
      chk16("rst_async", 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk32("rst_hold", 0, 1'b0);
         chk16("rst_hold", 0, 1'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk32("rst_rel_pre", 0, 1'b0);
      @(posedge clk);
      #1;
      chk32("rst_rel", 0, 1'b1);
      chk16("rst_rel", 0, 1'b1);

      // Directed 32-bit and 16-bit values
      step(32'h4900_00C9, 16'h8000);
      chk32("d4900", 1, 1'b1);
      chk16("d8000", 0, 1'b1);
      step(32'h0049_00C9, 16'h0100);
      chk32("d0049", 9, 1'b1);
      chk16("d0100", 7, 1'b1);
      @(negedge clk);
      b32.in = 32'h0000_40C9;
      b16.in = 16'h0001;
      #1;
      chk32("latency_hold", 9, 1'b1);
      @(posedge clk);
      #1;
      chk32("d40C9", 17, 1'b1);
      chk16("d0001", 15, 1'b1);
      step(32'h0000_04C9, 16'h0000);
      chk32("d04C9", 21, 1'b1);
      chk16("dzero16", 0, 1'b0);
      step(32'h8000_0000, 16'hFFFF);
      chk32("msb", 0, 1'b1);
      chk16("ones16", 0, 1'b1);
      step(32'h0000_0001, 16'h0003);
      chk32("lsb", 31, 1'b1);
      chk16("d0003", 14, 1'b1);
      step(32'h0000_0000, 16'h7FFF);
      chk32("zero32", 0, 1'b0);
      chk16("d7FFF", 1, 1'b1);

      // Walking one, back to back
      for (int i = 0; i < 32; i++) begin
         r32 = 32'h8000_0000 >> i;
         r16 = 16'h8000 >> (i % 16);
         step(r32, r16);
         chk32($sformatf("walk%0d", i), i, 1'b1);
         chk16($sformatf("walk%0d", i), i % 16, 1'b1);
      end

      // Reset mid-cycle
      step(32'h0000_0100, 16'h0010);
      chk32("pre_mrst", 23, 1'b1);
      chk16("pre_mrst", 11, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk32("mid_rst", 0, 1'b0);
      chk16("mid_rst", 0, 1'b0);
      @(posedge clk);
      #1;
      chk32("mid_rst_hold", 0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      b32.in = 32'h0200_0000;
      b16.in = 16'h0020;
      #1;
      chk32("mid_rst_rel", 0, 1'b0);
      @(posedge clk);
      #1;
      chk32("resume", 6, 1'b1);
      chk16("resume", 10, 1'b1);

      // Random sweep with varied leading-zero depth
      for (int i = 0; i < 300; i++) begin
         r32 = $urandom >> $urandom_range(0, 32);
         r16 = 16'($urandom) >> $urandom_range(0, 16);
         step(r32, r16);
         chk32($sformatf("rnd%0d_%h", i, r32),
               lz_ref(r32, 32), r32 != 0);
         chk16($sformatf("rnd%0d_%h", i, r16),
               lz_ref({16'h0, r16}, 16), r16 != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
